// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-side pointer/flag logic with a one-entry FWFT output stage
module fifo_rd_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int AE_THRESH = 2
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDR_W:0]   rq2_wptr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [ADDR_W:0]   rlevel
);
  localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AE_THRESH);
  logic [ADDR_W:0] rbin, rbinnext, rgraynext, wbin, level_next;
  logic pop;
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDR_W; i++) wbin[i] = ^(rq2_wptr >> i);
  end
  assign pop = !rempty && (!rvalid || rready);
  assign rbinnext = rbin + {{ADDR_W{1'b0}}, pop};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign level_next = wbin - rbinnext;
  assign raddr = rbin[ADDR_W-1:0];
  // A pop refills the output stage in the same cycle it is drained, giving one word per cycle
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin <= '0;
      rptr <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
      rempty <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel <= '0;
    end else begin
      rbin <= rbinnext;
      rptr <= rgraynext;
      rempty <= rgraynext == rq2_wptr;
      rlevel <= level_next;
      ralmost_empty <= level_next <= AE;
      rdata <= pop ? mem_rdata : rdata;
      rvalid <= pop || (rvalid && !rready);
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and random checks of fifo_rd_ctrl against a queue-based FIFO model
module tb_fifo_rd_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;
  logic rclk = 0;
  logic rrst = 1;
  logic rready = 0;
  logic [AW:0] rq2_wptr = '0;
  logic [DW-1:0] mem [8];
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] raddr;
  logic [AW:0] rptr;
  logic [DW-1:0] rdata;
  logic rvalid;
  logic rempty;
  logic ralmost_empty;
  logic [AW:0] rlevel;
  int checks = 0;
  int failures = 0;
  int wr = 0;
  int rd = 0;
  int m_lvl = 0;
  logic m_valid = 0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] q [$];

  fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AE_THRESH(2)) dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .mem_rdata(mem_rdata),
    .raddr(raddr), .rptr(rptr), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel)
  );

  assign mem_rdata = mem[raddr];
  always #5 rclk = ~rclk;

  function automatic logic [AW:0] g(int n);
    logic [AW:0] b;
    b = (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string t);
    chk({t, ":rvalid"}, 32'(rvalid), 32'(m_valid));
    chk({t, ":rdata"}, 32'(rdata), 32'(m_data));
    chk({t, ":rempty"}, 32'(rempty), 32'(m_lvl == 0));
    chk({t, ":rlevel"}, 32'(rlevel), 32'(m_lvl));
    chk({t, ":ralmost_empty"}, 32'(ralmost_empty), 32'(m_lvl <= 2));
    chk({t, ":rptr"}, 32'(rptr), 32'(g(rd)));
    chk({t, ":raddr"}, 32'(raddr), 32'(rd % 8));
  endtask

  task automatic wr_add(int n, logic [DW-1:0] base, bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] v;
      v = rnd ? DW'($urandom) : base + DW'(i);
      mem[wr % 8] = v;
      q.push_back(v);
      wr++;
    end
    rq2_wptr = g(wr);
  endtask

  task automatic cycle(string t);
    logic p;
    p = (m_lvl != 0) && (!m_valid || rready);
    @(posedge rclk);
    #1;
    if (p) begin
      m_data = q.pop_front();
      m_valid = 1;
      rd++;
    end else if (m_valid && rready) m_valid = 0;
    m_lvl = q.size();
    check_all(t);
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data = '0;
    m_lvl = 0;
    rd = 0;
    wr = 0;
    q.delete();
  endtask

  task automatic async_reset(string t);
    #2 rrst = 1;
    #1;
    model_reset();
    check_all({t, ":async"});
    rq2_wptr = '0;
    @(posedge rclk);
    #1 rrst = 0;
    check_all({t, ":rel"});
  endtask

  initial begin
    logic [AW:0] prev;
    int rd0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    // 1: reset
    repeat (3) @(posedge rclk);
    #1 rrst = 0;
    model_reset();
    check_all("t1");
    chk("t1:rempty_const", 32'(rempty), 32'd1);
    async_reset("t1");
    // 2: single word with held backpressure
    wr_add(1, 8'hA5, 0);
    cycle("t2_e1");
    chk("t2_e1:rlevel1", 32'(rlevel), 32'd1);
    cycle("t2_e2");
    chk("t2_e2:rdata_a5", 32'(rdata), 32'hA5);
    chk("t2_e2:rptr", 32'(rptr), 32'b0001);
    for (int i = 0; i < 5; i++) cycle("t2_hold");
    rready = 1;
    cycle("t2_acc");
    chk("t2_acc:rvalid0", 32'(rvalid), 32'd0);
    rready = 0;
    cycle("t2_idle");
    // 3 and 4: continuous stream, then wrap
    async_reset("t3pre");
    rready = 1;
    wr_add(8, 8'h10, 0);
    for (int i = 0; i < 11; i++) cycle("t3");
    chk("t3:rptr_end", 32'(rptr), 32'b1100);
    wr_add(8, 8'h20, 0);
    for (int i = 0; i < 11; i++) begin
      prev = rptr;
      rd0 = rd;
      cycle("t4");
      chk("t4:gray1", 32'($countones(rptr ^ prev)), 32'(rd - rd0));
    end
    chk("t4:rptr_end", 32'(rptr), 32'b0000);
    // 5: backpressure with three words
    async_reset("t5pre");
    rready = 0;
    wr_add(3, 8'h40, 0);
    for (int i = 0; i < 4; i++) cycle("t5_bp");
    chk("t5:rlevel2", 32'(rlevel), 32'd2);
    rready = 1;
    for (int i = 0; i < 4; i++) cycle("t5_go");
    // 6: reset during a stream
    async_reset("t6pre");
    wr_add(8, 8'h10, 0);
    while (rd < 4) cycle("t6");
    async_reset("t6");
    chk("t6:rvalid0", 32'(rvalid), 32'd0);
    for (int i = 0; i < 3; i++) cycle("t6_idle");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rready = 1'($urandom);
      if ($urandom_range(0, 2) != 0) wr_add($urandom_range(0, 8 - q.size()), 8'h0, 1);
      cycle("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
